// File: rtl/bpu_upd_sched.sv
// Update-path sequencer for the branch predictor: sweeps the PHT after reset, then queues
// retire-port update records and issues one per cycle, yielding to fetch BTB lookups for a bounded time.
module bpu_upd_sched #(
   parameter int unsigned UPD_W     = 64,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned PHT_IDX_W = 8,
   parameter int unsigned MAX_DEFER = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_flush,
   input  logic                 i_bpu_rd_busy,
   input  logic                 i_upd0_vld,
   input  logic [UPD_W-1:0]     i_upd0_info,
   output logic                 o_upd0_rdy,
   input  logic                 i_upd1_vld,
   input  logic [UPD_W-1:0]     i_upd1_info,
   output logic                 o_upd1_rdy,
   output logic                 o_bpu_upd_vld,
   output logic [UPD_W-1:0]     o_bpu_upd_info,
   output logic                 o_bpu_init_vld,
   output logic [PHT_IDX_W-1:0] o_bpu_init_idx,
   output logic                 o_busy
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned DEF_W = (MAX_DEFER < 1) ? 1 : $clog2(MAX_DEFER + 1);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t               state, state_nxt;
   logic [PHT_IDX_W-1:0] init_cnt;
   logic [UPD_W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr, wr_ptr1, rd_ptr;
   logic [CNT_W-1:0]     cnt, cnt_nxt, free;
   logic [DEF_W-1:0]     defer_cnt;
   logic                 init_act, run, head_vld, defer_max;
   logic                 acc0, acc1, pop, defer_inc;

   always_ff @(posedge clk) begin
      if (rst) state <= S_INIT;
      else     state <= state_nxt;
   end

   // Next state; reset masks every strobe so outputs stay quiet while rst is high
   always_comb begin
      state_nxt = state;
      init_act  = 1'b0;
      run       = 1'b0;
      case (state)
         S_INIT: begin
            init_act = 1'b1;
            if (init_cnt == {PHT_IDX_W{1'b1}}) state_nxt = S_RUN;
         end
         S_RUN:   run = 1'b1;
         default: state_nxt = S_INIT;
      endcase
      if (rst) begin
         init_act = 1'b0;
         run      = 1'b0;
      end
   end

   // Space is judged on registered occupancy; a same-cycle pop never frees a slot
   assign free       = CNT_W'(DEPTH) - cnt;
   assign head_vld   = (cnt != '0);
   assign defer_max  = (defer_cnt == DEF_W'(MAX_DEFER));
   assign o_upd0_rdy = run & (free >= CNT_W'(1));
   assign o_upd1_rdy = run & ((free >= CNT_W'(2)) | ((free == CNT_W'(1)) & ~i_upd0_vld));
   assign acc0       = i_upd0_vld & o_upd0_rdy;
   assign acc1       = i_upd1_vld & o_upd1_rdy;
   assign pop        = run & head_vld & ~i_flush & (~i_bpu_rd_busy | defer_max);
   assign defer_inc  = run & head_vld & ~i_flush & i_bpu_rd_busy & ~defer_max;
   assign wr_ptr1    = wr_ptr + PTR_W'(1);
   assign cnt_nxt    = cnt + CNT_W'(acc0) + CNT_W'(acc1) - CNT_W'(pop);

   assign o_bpu_upd_vld  = pop;
   assign o_bpu_upd_info = (run & head_vld) ? mem[rd_ptr] : '0;
   assign o_bpu_init_vld = init_act;
   assign o_bpu_init_idx = init_act ? init_cnt : '0;
   assign o_busy         = rst | (state == S_INIT) | head_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         init_cnt  <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         defer_cnt <= '0;
      end else begin
         if (init_act) init_cnt <= init_cnt + PHT_IDX_W'(1);
         wr_ptr <= wr_ptr + PTR_W'(acc0) + PTR_W'(acc1);
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         cnt <= cnt_nxt;
         if (pop)            defer_cnt <= '0;
         else if (defer_inc) defer_cnt <= defer_cnt + DEF_W'(1);
      end
   end

   // Port 1 lands behind port 0 when both are accepted, preserving program order
   always_ff @(posedge clk) begin
      if (acc0) mem[wr_ptr] <= i_upd0_info;
      if (acc1) mem[acc0 ? wr_ptr1 : wr_ptr] <= i_upd1_info;
   end

endmodule

// File: tb/tb_bpu_upd_sched.sv
// Directed bench for bpu_upd_sched: init sweep, dual enqueue, defer bound, full queue, flush and reset.
module tb_bpu_upd_sched;

   localparam int unsigned UPD_W     = 64;
   localparam int unsigned PHT_IDX_W = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 i_flush, i_bpu_rd_busy;
   logic                 i_upd0_vld, i_upd1_vld;
   logic [UPD_W-1:0]     i_upd0_info, i_upd1_info;
   logic                 o_upd0_rdy, o_upd1_rdy;
   logic                 o_bpu_upd_vld, o_bpu_init_vld, o_busy;
   logic [UPD_W-1:0]     o_bpu_upd_info;
   logic [PHT_IDX_W-1:0] o_bpu_init_idx;

   int n_chk  = 0;
   int n_pass = 0;

   bpu_upd_sched #(.UPD_W(UPD_W), .DEPTH(4), .PHT_IDX_W(PHT_IDX_W), .MAX_DEFER(3)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_flush        (i_flush),
      .i_bpu_rd_busy  (i_bpu_rd_busy),
      .i_upd0_vld     (i_upd0_vld),
      .i_upd0_info    (i_upd0_info),
      .o_upd0_rdy     (o_upd0_rdy),
      .i_upd1_vld     (i_upd1_vld),
      .i_upd1_info    (i_upd1_info),
      .o_upd1_rdy     (o_upd1_rdy),
      .o_bpu_upd_vld  (o_bpu_upd_vld),
      .o_bpu_upd_info (o_bpu_upd_info),
      .o_bpu_init_vld (o_bpu_init_vld),
      .o_bpu_init_idx (o_bpu_init_idx),
      .o_busy         (o_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Inputs change 1 time unit after the edge; outputs are sampled 2 units later
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic sweep(input string tag);
      int n = 0;
      int order_err = 0;
      int rdy_err = 0;
      while (o_bpu_init_vld && n < 400) begin
         if (o_bpu_init_idx != PHT_IDX_W'(n)) order_err++;
         if (o_upd0_rdy || o_upd1_rdy || o_bpu_upd_vld) rdy_err++;
         n++;
         nxt();
         #2;
      end
      chk({tag, "_len"},   64'(n), 64'd256);
      chk({tag, "_order"}, 64'(order_err), 64'd0);
      chk({tag, "_rdy"},   64'(rdy_err), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; i_flush = 1'b0; i_bpu_rd_busy = 1'b0;
      i_upd0_vld = 1'b0; i_upd1_vld = 1'b0; i_upd0_info = '0; i_upd1_info = '0;

      nxt(); nxt(); #2;
      chk("rst_init_vld", o_bpu_init_vld, 1'b0);
      chk("rst_busy",     o_busy,         1'b1);
      chk("rst_rdy0",     o_upd0_rdy,     1'b0);
      chk("rst_upd_vld",  o_bpu_upd_vld,  1'b0);

      // INIT ignores flush and fetch reads
      nxt(); rst = 1'b0; i_flush = 1'b1; i_bpu_rd_busy = 1'b1; #2;
      sweep("init");
      chk("run_busy",     o_busy,         1'b0);
      chk("run_init_vld", o_bpu_init_vld, 1'b0);
      chk("run_rdy0",     o_upd0_rdy,     1'b1);
      chk("run_rdy1",     o_upd1_rdy,     1'b1);

      // Dual enqueue, issued in program order
      nxt(); i_flush = 1'b0; i_bpu_rd_busy = 1'b0;
      i_upd0_vld = 1'b1; i_upd0_info = 64'hA; i_upd1_vld = 1'b1; i_upd1_info = 64'hB; #2;
      chk("dual_noissue", o_bpu_upd_vld, 1'b0);
      nxt(); i_upd0_vld = 1'b0; i_upd1_vld = 1'b0; #2;
      chk("dual_vld0",  o_bpu_upd_vld,  1'b1);
      chk("dual_info0", o_bpu_upd_info, 64'hA);
      nxt(); #2;
      chk("dual_vld1",  o_bpu_upd_vld,  1'b1);
      chk("dual_info1", o_bpu_upd_info, 64'hB);
      nxt(); #2;
      chk("dual_empty_vld",  o_bpu_upd_vld,  1'b0);
      chk("dual_empty_busy", o_busy,         1'b0);
      chk("dual_empty_info", o_bpu_upd_info, 64'h0);

      // Fetch reads defer the head for at most 3 cycles
      nxt(); i_upd0_vld = 1'b1; i_upd0_info = 64'h33; #2;
      nxt(); i_upd0_vld = 1'b0; i_bpu_rd_busy = 1'b1; #2;
      chk("defer_a0", o_bpu_upd_vld, 1'b0);
      nxt(); #2; chk("defer_a1", o_bpu_upd_vld, 1'b0);
      nxt(); #2; chk("defer_a2", o_bpu_upd_vld, 1'b0);
      nxt(); i_upd0_vld = 1'b1; i_upd0_info = 64'h44; #2;
      chk("defer_force_vld",  o_bpu_upd_vld,  1'b1);
      chk("defer_force_info", o_bpu_upd_info, 64'h33);
      nxt(); i_upd0_vld = 1'b0; #2;
      chk("defer_b0", o_bpu_upd_vld, 1'b0);
      nxt(); #2; chk("defer_b1", o_bpu_upd_vld, 1'b0);
      nxt(); #2; chk("defer_b2", o_bpu_upd_vld, 1'b0);
      nxt(); #2;
      chk("defer_force2_vld",  o_bpu_upd_vld,  1'b1);
      chk("defer_force2_info", o_bpu_upd_info, 64'h44);
      nxt(); i_bpu_rd_busy = 1'b0; #2;
      chk("defer_empty", o_busy, 1'b0);

      // Fill to capacity while flush blocks issue
      nxt(); i_flush = 1'b1;
      i_upd0_vld = 1'b1; i_upd0_info = 64'h1; i_upd1_vld = 1'b1; i_upd1_info = 64'h2; #2;
      nxt(); i_upd0_info = 64'h3; i_upd1_vld = 1'b0; #2;
      nxt(); i_upd0_info = 64'h4; i_upd1_vld = 1'b1; i_upd1_info = 64'h5; #2;
      chk("full3_rdy0", o_upd0_rdy, 1'b1);
      chk("full3_rdy1", o_upd1_rdy, 1'b0);
      nxt(); i_upd0_info = 64'h6; i_upd1_info = 64'h7; #2;
      chk("full4_rdy0", o_upd0_rdy, 1'b0);
      chk("full4_rdy1", o_upd1_rdy, 1'b0);
      nxt(); i_flush = 1'b0; #2;
      chk("fullpop_vld",  o_bpu_upd_vld,  1'b1);
      chk("fullpop_info", o_bpu_upd_info, 64'h1);
      chk("fullpop_rdy0", o_upd0_rdy,     1'b0);
      chk("fullpop_rdy1", o_upd1_rdy,     1'b0);
      nxt(); i_upd0_vld = 1'b0; i_upd1_vld = 1'b0; #2;
      chk("drain_2", o_bpu_upd_info, 64'h2);
      nxt(); #2; chk("drain_3", o_bpu_upd_info, 64'h3);
      nxt(); #2; chk("drain_4", o_bpu_upd_info, 64'h4);
      chk("drain_4_vld", o_bpu_upd_vld, 1'b1);
      nxt(); #2;
      chk("drain_empty_vld",  o_bpu_upd_vld, 1'b0);
      chk("drain_empty_busy", o_busy,        1'b0);

      // Flush holds issue but keeps entries
      nxt(); i_upd0_vld = 1'b1; i_upd0_info = 64'h55; i_upd1_vld = 1'b1; i_upd1_info = 64'h66; #2;
      nxt(); i_upd0_vld = 1'b0; i_upd1_vld = 1'b0; i_flush = 1'b1; #2;
      chk("flush_c0", o_bpu_upd_vld, 1'b0);
      nxt(); #2;
      chk("flush_c1", o_bpu_upd_vld, 1'b0);
      chk("flush_busy", o_busy, 1'b1);
      nxt(); i_flush = 1'b0; #2;
      chk("flush_out0", o_bpu_upd_info, 64'h55);
      chk("flush_vld0", o_bpu_upd_vld,  1'b1);
      nxt(); #2;
      chk("flush_out1", o_bpu_upd_info, 64'h66);
      chk("flush_vld1", o_bpu_upd_vld,  1'b1);
      nxt(); #2;
      chk("flush_empty", o_bpu_upd_vld, 1'b0);

      // Reset with three entries queued drops them and restarts the sweep
      nxt(); i_flush = 1'b1;
      i_upd0_vld = 1'b1; i_upd0_info = 64'h7; i_upd1_vld = 1'b1; i_upd1_info = 64'h8; #2;
      nxt(); i_upd0_info = 64'h9; i_upd1_vld = 1'b0; #2;
      nxt(); i_upd0_vld = 1'b0; i_flush = 1'b0; rst = 1'b1; #2;
      chk("rst2_upd_vld", o_bpu_upd_vld, 1'b0);
      chk("rst2_busy",    o_busy,        1'b1);
      chk("rst2_info",    o_bpu_upd_info, 64'h0);
      nxt(); rst = 1'b0; i_flush = 1'b1; i_bpu_rd_busy = 1'b1; #2;
      chk("rst2_init_vld", o_bpu_init_vld, 1'b1);
      chk("rst2_init_idx", o_bpu_init_idx, 8'd0);
      chk("rst2_upd_vld2", o_bpu_upd_vld,  1'b0);
      sweep("reinit");
      chk("reinit_busy", o_busy,         1'b0);
      chk("reinit_vld",  o_bpu_upd_vld,  1'b0);
      chk("reinit_info", o_bpu_upd_info, 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/bpu_upd_sched.md
Name: bpu_upd_sched

Overview:
- Sequences all writes into the branch predictor's update path: the gshare PHT and the BTB clear, mispredict and new-branch ports.
- Queues resolved-branch update records from two instruction-queue retire ports.
- Issues at most one record per cycle, giving way to fetch-side BTB lookups with bounded deferral.
- After reset, sweeps the PHT to a known state before any update is accepted.
- Sits between the IQ retire logic and bpu_module's i_iq_bpu_* inputs.

Parameters:
- UPD_W, 64: width of one opaque update record (vld/taken/new_br/type/addr/taddr/idx/pht fields, packed by the IQ).
- DEPTH, 4: queue entries; power of two, at least 2.
- PHT_IDX_W, 8: PHT index width; the init sweep covers 2^PHT_IDX_W entries.
- MAX_DEFER, 3: maximum consecutive cycles a ready head entry may be held off by fetch reads.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_flush  in  1  OR of trap, mispredict and load/store flush; blocks issue in the current cycle only.
- i_bpu_rd_busy  in  1  fetch-side BTB lookup active this cycle (ifu_bpu_vld | predec_icache_done).
- i_upd0_vld  in  1  retire port 0 update request.
- i_upd0_info  in  UPD_W  retire port 0 record.
- o_upd0_rdy  out  1  port 0 accepted when vld & rdy.
- i_upd1_vld  in  1  retire port 1 update request.
- i_upd1_info  in  UPD_W  retire port 1 record.
- o_upd1_rdy  out  1  port 1 accepted when vld & rdy.
- o_bpu_upd_vld  out  1  issue one record to the BPU this cycle.
- o_bpu_upd_info  out  UPD_W  record being issued (queue head).
- o_bpu_init_vld  out  1  PHT init write this cycle.
- o_bpu_init_idx  out  PHT_IDX_W  PHT index to write with 2'b01 (weakly not-taken).
- o_busy  out  1  high in INIT or when the queue is non-empty.

Behaviour:
Reset (synchronous, rst high at a clock edge):
- state=INIT, init_cnt=0, queue empty (wr_ptr=rd_ptr=cnt=0), defer_cnt=0.
- All outputs are 0 during and immediately after reset, except o_busy=1.
- Reset asserted mid-operation drops every queued record and restarts INIT.

FSM, two states:
- INIT:
  - Every cycle: o_bpu_init_vld=1, o_bpu_init_idx=init_cnt, init_cnt+=1.
  - o_upd0_rdy=o_upd1_rdy=0; o_bpu_upd_vld=0.
  - i_flush and i_bpu_rd_busy are ignored.
  - When init_cnt==2^PHT_IDX_W-1, go to RUN. The sweep lasts exactly 2^PHT_IDX_W cycles (256 at default).
- RUN: o_bpu_init_vld=0. The FSM never returns to INIT except through rst.

Enqueue (RUN only):
- free = DEPTH - cnt, using registered cnt. A dequeue in the same cycle does not create space for that cycle.
- o_upd0_rdy = (free>=1).
- o_upd1_rdy = (free>=2) | (free==1 & ~i_upd0_vld).
- Both ports accepted in one cycle: port 0 is written at wr_ptr, port 1 at wr_ptr+1 (program order).
- wr_ptr wraps modulo DEPTH.

Issue (RUN only):
- head_vld = (cnt!=0).
- o_bpu_upd_vld = head_vld & ~i_flush & (~i_bpu_rd_busy | defer_cnt==MAX_DEFER).
- o_bpu_upd_info = entry at rd_ptr whenever head_vld, else 0.
- When o_bpu_upd_vld=1: pop (rd_ptr+=1 with wrap) and defer_cnt=0.
- Minimum latency: a record accepted at edge N is issued no earlier than the cycle after N.
- Fetch reads win when head_vld & ~i_flush & i_bpu_rd_busy & defer_cnt<MAX_DEFER; then defer_cnt+=1.
- i_flush holds defer_cnt unchanged, issues nothing, and keeps all queued entries.
- cnt update: cnt_next = cnt + accepts - pop, where accepts is 0, 1 or 2. Never exceeds DEPTH; never underflows.

Test Plan:
- Reset then idle, PHT_IDX_W=8 → o_bpu_init_vld high for exactly 256 cycles with idx 0..255 in order; rdy low throughout; o_busy falls the first cycle after INIT with the queue empty.
- RUN, empty queue, upd0 info=0xA and upd1 info=0xB in the same cycle, rd_busy=0 → 0xA issued next cycle, 0xB the cycle after; o_busy drops after that.
- rd_busy held 1 with one entry queued, MAX_DEFER=3 → 3 cycles with no issue, forced issue on the 4th cycle, defer_cnt returns to 0.
- Queue at cnt=3 with both ports valid → only port 0 accepted (rdy1=0); at cnt=4 both rdy=0; a same-cycle pop does not raise rdy.
- Flush asserted for 2 cycles with 2 entries queued → no issue in those cycles, both entries issued afterwards in order, none lost.
- rst pulsed with 3 entries queued → queue empties, o_bpu_upd_vld=0, INIT sweep restarts at idx 0.
